// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control unit: Moore sequencing FSM, ALU decoder,
// conditional-execution check and the NZCV flag register.
module arm_multicycle_ctrl (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECR   = 4'd6,
    S_EXECI   = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_UNKNOWN = 4'd10
  } state_t;

  state_t     state_q, state_d;
  logic       cond_q;
  logic [3:0] flags_q;

  logic       next_pc_s, branch_s, reg_w_s, mem_w_s, ir_write_s, alu_op_s;
  logic       adr_src_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, result_src_s;
  logic [1:0] alu_control_s, flag_w_s;
  logic       cond_ex_s, rd_is_pc_s, pcs_s;

  // Condition-field evaluation against the registered NZCV flags.
  function automatic logic cond_ex_f(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_ex_f = z;
      4'b0001: cond_ex_f = ~z;
      4'b0010: cond_ex_f = cf;
      4'b0011: cond_ex_f = ~cf;
      4'b0100: cond_ex_f = n;
      4'b0101: cond_ex_f = ~n;
      4'b0110: cond_ex_f = v;
      4'b0111: cond_ex_f = ~v;
      4'b1000: cond_ex_f = cf & ~z;
      4'b1001: cond_ex_f = ~cf | z;
      4'b1010: cond_ex_f = (n == v);
      4'b1011: cond_ex_f = (n != v);
      4'b1100: cond_ex_f = ~z & (n == v);
      4'b1101: cond_ex_f = z | (n != v);
      4'b1110: cond_ex_f = 1'b1;
      default: cond_ex_f = 1'b0;
    endcase
  endfunction

  assign cond_ex_s  = cond_ex_f(Cond, flags_q);
  assign rd_is_pc_s = (Rd == 4'd15);

  // Next-state selection; any unused state code recovers to FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: state_d = S_UNKNOWN;
        endcase
      end
      S_MEMADR: state_d = Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR:  state_d = S_ALUWB;
      S_EXECI:  state_d = S_ALUWB;
      default:  state_d = S_FETCH;
    endcase
  end

  // Moore raw controls decoded from the current state.
  always_comb begin
    next_pc_s    = 1'b0;
    branch_s     = 1'b0;
    reg_w_s      = 1'b0;
    mem_w_s      = 1'b0;
    ir_write_s   = 1'b0;
    alu_op_s     = 1'b0;
    adr_src_s    = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = 2'b00;
    result_src_s = 2'b00;
    case (state_q)
      S_FETCH: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
        ir_write_s   = 1'b1;
        next_pc_s    = 1'b1;
      end
      S_DECODE: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = 2'b10;
        result_src_s = 2'b10;
      end
      S_MEMADR: alu_src_b_s = 2'b01;
      S_EXECI: begin
        alu_src_b_s = 2'b01;
        alu_op_s    = 1'b1;
      end
      S_EXECR:  alu_op_s = 1'b1;
      S_MEMRD:  adr_src_s = 1'b1;
      S_MEMWB: begin
        result_src_s = 2'b01;
        reg_w_s      = 1'b1;
      end
      S_MEMWR: begin
        adr_src_s = 1'b1;
        mem_w_s   = 1'b1;
      end
      S_ALUWB:  reg_w_s = 1'b1;
      S_BRANCH: begin
        alu_src_b_s  = 2'b01;
        result_src_s = 2'b10;
        branch_s     = 1'b1;
      end
      default: begin
        next_pc_s = 1'b0;
      end
    endcase
  end

  // ALU decoder: operation select and which flag groups may update.
  always_comb begin
    alu_control_s = 2'b00;
    flag_w_s      = 2'b00;
    if (alu_op_s) begin
      case (Funct[4:1])
        4'b0100: begin alu_control_s = 2'b00; flag_w_s = Funct[0] ? 2'b11 : 2'b00; end
        4'b0010: begin alu_control_s = 2'b01; flag_w_s = Funct[0] ? 2'b11 : 2'b00; end
        4'b0000: begin alu_control_s = 2'b10; flag_w_s = Funct[0] ? 2'b10 : 2'b00; end
        4'b1100: begin alu_control_s = 2'b11; flag_w_s = Funct[0] ? 2'b10 : 2'b00; end
        default: begin alu_control_s = 2'b00; flag_w_s = 2'b00; end
      endcase
    end else begin
      alu_control_s = 2'b00;
      flag_w_s      = 2'b00;
    end
  end

  // State, latched condition outcome and NZCV flags; the condition is
  // frozen at the end of DECODE so a flag write in EXEC cannot change it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
      cond_q  <= 1'b0;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cond_q <= cond_ex_s;
      if ((state_q == S_EXECR) || (state_q == S_EXECI)) begin
        if (flag_w_s[1] & cond_q) flags_q[3:2] <= ALUFlags[3:2];
        if (flag_w_s[0] & cond_q) flags_q[1:0] <= ALUFlags[1:0];
      end
    end
  end

  // Write strobes are held low asynchronously while reset is asserted.
  assign pcs_s      = branch_s | (reg_w_s & rd_is_pc_s);
  assign PCWrite    = reset_n & (next_pc_s | (pcs_s & cond_q));
  assign IRWrite    = reset_n & ir_write_s;
  assign RegWrite   = reset_n & reg_w_s & cond_q & ~rd_is_pc_s;
  assign MemWrite   = reset_n & mem_w_s & cond_q;
  assign AdrSrc     = adr_src_s;
  assign ALUSrcA    = alu_src_a_s;
  assign ALUSrcB    = alu_src_b_s;
  assign ResultSrc  = result_src_s;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
  assign ALUControl = alu_control_s;
  assign Flags      = flags_q;
  assign Illegal    = (state_q == S_UNKNOWN);
  assign State      = state_q;

endmodule
